// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_pkg
//  Description : Shared types and constants for the ALU operand sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

   // Operand-entry steps, in the order the user walks through them.
   typedef enum logic [1:0] {
      ENTER_A  = 2'd0,
      ENTER_B  = 2'd1,
      ENTER_OP = 2'd2,
      SHOW_RES = 2'd3
   } seq_state_t;

   // LED pattern of the first step; the other steps are shifted copies.
   localparam logic [3:0] c_STEP_LED_BASE = 4'b0001;

   // One-hot LED pattern for a given step.
   function automatic logic [3:0] step_led(input seq_state_t s);
      return c_STEP_LED_BASE << s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debouncer
//  Description : 2-flop synchronizer, stability-count debouncer and rising
//                edge detector producing a one-cycle press pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debouncer #(
   parameter int DB_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic press
);

   localparam int              CW        = $clog2(DB_CYCLES);
   localparam logic [CW-1:0]   c_CNT_MAX = CW'(DB_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic [CW-1:0] r_cnt;
   logic          r_db;
   logic          r_db_d;
   logic          r_press;

   // Bring the raw button into the clock domain.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= btn_raw;
         r_sync2 <= r_sync1;
      end
   end

   // Flip the debounced level only after DB_CYCLES consecutive differing
   // samples; any sample matching the current level restarts the count.
   // The counter stops at its maximum and is cleared on the flip, so it
   // never wraps.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
         r_db  <= 1'b0;
      end else if (r_sync2 == r_db) begin
         r_cnt <= '0;
      end else if (r_cnt == c_CNT_MAX) begin
         r_db  <= r_sync2;
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Registered one-cycle pulse on each debounced rising edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_db_d  <= 1'b0;
         r_press <= 1'b0;
      end else begin
         r_db_d  <= r_db;
         r_press <= r_db & ~r_db_d;
      end
   end

   assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/alu_operand_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_operand_sequencer
//  Description : Turns debounced enter/clear buttons and the board switches
//                into the load_A / load_B / load_Op / updateRes strobe
//                sequence consumed by the ALU register block.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_sequencer
   import alu_seq_pkg::*;
#(
   parameter int N         = 16,
   parameter int OP_W      = 2,
   parameter int DB_CYCLES = 500000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] switches,
   input  logic         btn_enter,
   input  logic         btn_clear,
   output logic [N-1:0] data_in,
   output logic         load_A,
   output logic         load_B,
   output logic         load_Op,
   output logic         updateRes,
   output logic [3:0]   step_leds
);

   logic         w_ent_press;
   logic         w_clr_press;

   seq_state_t   r_state;
   seq_state_t   w_state_next;
   logic [3:0]   r_strobe;       // {updateRes, load_Op, load_B, load_A}
   logic [3:0]   w_strobe_next;
   logic [N-1:0] r_data;
   logic [N-1:0] w_data_next;

   btn_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_enter (
      .clk     (clk),
      .reset   (reset),
      .btn_raw (btn_enter),
      .press   (w_ent_press)
   );

   btn_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
      .clk     (clk),
      .reset   (reset),
      .btn_raw (btn_clear),
      .press   (w_clr_press)
   );

   // State, strobe and data registers; strobes last exactly one cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= ENTER_A;
         r_strobe <= '0;
         r_data   <= '0;
      end else begin
         r_state  <= w_state_next;
         r_strobe <= w_strobe_next;
         r_data   <= w_data_next;
      end
   end

   // Step sequencing; clear takes priority over a simultaneous enter.
   always_comb begin
      w_state_next  = r_state;
      w_strobe_next = '0;
      w_data_next   = r_data;
      if (w_clr_press) begin
         w_state_next = ENTER_A;
      end else if (w_ent_press) begin
         case (r_state)
            ENTER_A: begin
               w_state_next  = ENTER_B;
               w_strobe_next = 4'b0001;
               w_data_next   = switches;
            end
            ENTER_B: begin
               w_state_next  = ENTER_OP;
               w_strobe_next = 4'b0010;
               w_data_next   = switches;
            end
            ENTER_OP: begin
               w_state_next  = SHOW_RES;
               w_strobe_next = 4'b0100;
               w_data_next   = {{(N-OP_W){1'b0}}, switches[OP_W-1:0]};
            end
            SHOW_RES: begin
               // Result latch: data_in keeps the opcode value.
               w_state_next  = ENTER_A;
               w_strobe_next = 4'b1000;
            end
            default: begin
               w_state_next = ENTER_A;
            end
         endcase
      end
   end

   assign data_in   = r_data;
   assign load_A    = r_strobe[0];
   assign load_B    = r_strobe[1];
   assign load_Op   = r_strobe[2];
   assign updateRes = r_strobe[3];
   assign step_leds = step_led(r_state);

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_operand_sequencer
//  Description : Self-checking bench for alu_operand_sequencer (DB_CYCLES=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_operand_sequencer;

   localparam int N  = 16;
   localparam int DB = 4;

   typedef struct {
      logic [15:0] sw;
      logic [3:0]  strobe;   // {updateRes, load_Op, load_B, load_A}
      logic [15:0] data;
      logic [3:0]  leds;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  switches;
   logic          btn_enter;
   logic          btn_clear;
   logic [N-1:0]  data_in;
   logic          load_A, load_B, load_Op, updateRes;
   logic [3:0]    step_leds;

   int            n_vec  = 0;
   int            n_fail = 0;
   int            n_strobes = 0;
   vec_t          exp_q[$];
   vec_t          tbl[4];
   logic [3:0]    mon_s;
   vec_t          mon_e;

   alu_operand_sequencer #(.N(N), .OP_W(2), .DB_CYCLES(DB)) dut (
      .clk       (clk),
      .reset     (reset),
      .switches  (switches),
      .btn_enter (btn_enter),
      .btn_clear (btn_clear),
      .data_in   (data_in),
      .load_A    (load_A),
      .load_B    (load_B),
      .load_Op   (load_Op),
      .updateRes (updateRes),
      .step_leds (step_leds)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Scoreboard: every strobe seen is matched against the oldest expectation.
   always @(negedge clk) begin
      mon_s = {updateRes, load_Op, load_B, load_A};
      if (mon_s != 4'b0000) begin
         n_strobes++;
         check("one_hot_strobe", {31'd0, $countones(mon_s) == 1}, 32'd1);
         if (exp_q.size() == 0) begin
            check("unexpected_strobe", {28'd0, mon_s}, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("sb_strobe", {28'd0, mon_s},     {28'd0, mon_e.strobe});
            check("sb_data",   {16'd0, data_in},   {16'd0, mon_e.data});
            check("sb_leds",   {28'd0, step_leds}, {28'd0, mon_e.leds});
         end
      end
   end

   task automatic press_enter(input vec_t v, input int hold);
      @(negedge clk);
      switches  = v.sw;
      btn_enter = 1'b1;
      exp_q.push_back(v);
      repeat (hold) @(negedge clk);
      btn_enter = 1'b0;
      repeat (DB + 8) @(negedge clk);
      check("after_press_leds", {28'd0, step_leds}, {28'd0, v.leds});
      check("after_press_data", {16'd0, data_in},   {16'd0, v.data});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      vec_t v;
      int   lat;
      int   cnt0;
      bit   found;

      tbl[0] = '{sw: 16'h0017, strobe: 4'b0001, data: 16'h0017, leds: 4'b0010};
      tbl[1] = '{sw: 16'h0025, strobe: 4'b0010, data: 16'h0025, leds: 4'b0100};
      tbl[2] = '{sw: 16'hFFF3, strobe: 4'b0100, data: 16'h0003, leds: 4'b1000};
      tbl[3] = '{sw: 16'hABCD, strobe: 4'b1000, data: 16'h0003, leds: 4'b0001};

      reset = 1'b0; switches = '0; btn_enter = 1'b0; btn_clear = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_data",    {16'd0, data_in},   32'd0);
      check("rst_strobes", {28'd0, updateRes, load_Op, load_B, load_A}, 32'd0);
      check("rst_leds",    {28'd0, step_leds}, 32'd1);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Clean 10-cycle presses through the whole sequence.
      for (int i = 0; i < 4; i++) press_enter(tbl[i], 10);

      // Bouncing enter: only the final settled rise produces a strobe.
      cnt0 = n_strobes;
      @(negedge clk);
      switches = 16'h1234;
      for (int i = 0; i < 10; i++) begin
         btn_enter = (i % 2 == 0);
         repeat (2) @(negedge clk);
      end
      check("bounce_no_strobe", n_strobes - cnt0, 32'd0);
      btn_enter = 1'b1;
      exp_q.push_back('{sw: 16'h1234, strobe: 4'b0001, data: 16'h1234, leds: 4'b0010});
      lat = -1;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if ({updateRes, load_Op, load_B, load_A} != 4'b0000) begin
            lat = k;
            break;
         end
      end
      check("bounce_latency", lat, 32'd7);
      repeat (4) @(negedge clk);
      btn_enter = 1'b0;
      repeat (DB + 8) @(negedge clk);
      check("bounce_one_strobe", n_strobes - cnt0, 32'd1);

      // Enter and clear together in ENTER_OP: clear wins, nothing strobed.
      press_enter('{sw: 16'h0042, strobe: 4'b0010, data: 16'h0042, leds: 4'b0100}, 10);
      cnt0 = n_strobes;
      @(negedge clk);
      switches = 16'h7777; btn_enter = 1'b1; btn_clear = 1'b1;
      repeat (10) @(negedge clk);
      btn_enter = 1'b0; btn_clear = 1'b0;
      repeat (DB + 8) @(negedge clk);
      check("clr_no_strobe", n_strobes - cnt0, 32'd0);
      check("clr_leds", {28'd0, step_leds}, 32'd1);
      check("clr_data", {16'd0, data_in},   32'h0042);

      // Reset pulled during the load_B strobe cycle.
      press_enter('{sw: 16'h0011, strobe: 4'b0001, data: 16'h0011, leds: 4'b0010}, 10);
      @(negedge clk);
      switches = 16'h0022; btn_enter = 1'b1;
      exp_q.push_back('{sw: 16'h0022, strobe: 4'b0010, data: 16'h0022, leds: 4'b0100});
      found = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (load_B) begin
            found = 1'b1;
            break;
         end
      end
      check("rst_mid_strobe_seen", {31'd0, found}, 32'd1);
      #2;
      reset = 1'b0; btn_enter = 1'b0;
      #1;
      check("rst_mid_loadB", {31'd0, load_B},    32'd0);
      check("rst_mid_data",  {16'd0, data_in},   32'd0);
      check("rst_mid_leds",  {28'd0, step_leds}, 32'd1);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      cnt0 = n_strobes;
      repeat (20) @(negedge clk);
      check("rst_no_ghost_press", n_strobes - cnt0, 32'd0);
      press_enter('{sw: 16'h0033, strobe: 4'b0001, data: 16'h0033, leds: 4'b0010}, 10);

      // Long hold: one strobe only, next one needs release and a new press.
      cnt0 = n_strobes;
      press_enter('{sw: 16'h0055, strobe: 4'b0010, data: 16'h0055, leds: 4'b0100}, 100);
      check("hold_one_strobe", n_strobes - cnt0, 32'd1);
      press_enter('{sw: 16'h0066, strobe: 4'b0100, data: 16'h0002, leds: 4'b1000}, 10);
      check("hold_second_strobe", n_strobes - cnt0, 32'd2);

      check("sb_queue_drained", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_operand_sequencer.md
# alu_operand_sequencer

Operand-entry front end for the registered ALU: it turns one debounced "enter" button and the board switches into the `data_in` / `load_A` / `load_B` / `load_Op` / `updateRes` strobe sequence that the ALU register block consumes. It is the initiator side of the ALU load interface and replaces bench-driven stimulus on the board. It sits between the raw board I/O (switches, push buttons) and the ALU register block.

## Interface

Parameters:
- `N`, 16: operand width; equals the ALU register block's `N`.
- `OP_W`, 2: opcode width, carried on `data_in[OP_W-1:0]` during `load_Op`.
- `DB_CYCLES`, 500000: debounce stable-time in clock cycles (≥2).

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  reset, asynchronous, active-low.
- `switches`  in  N  operand/opcode value, asynchronous to `clk`.
- `btn_enter`  in  1  raw enter button, active-high, bouncing, asynchronous.
- `btn_clear`  in  1  raw clear button, active-high, bouncing, asynchronous.
- `data_in`  out  N  value presented to the ALU register block.
- `load_A`  out  1  one-cycle strobe, load operand A.
- `load_B`  out  1  one-cycle strobe, load operand B.
- `load_Op`  out  1  one-cycle strobe, load opcode.
- `updateRes`  out  1  one-cycle strobe, latch the ALU result.
- `step_leds`  out  4  one-hot current step, for the board LEDs.

## Operation

- Each button passes through a 2-flop synchronizer, then a debouncer. The debounced level changes only after the synchronized input has been stable for `DB_CYCLES` consecutive cycles. A rising edge of the debounced level produces a one-cycle `press` pulse.
- FSM states: `ENTER_A` → `ENTER_B` → `ENTER_OP` → `SHOW_RES` → `ENTER_A`. Each transition is taken on an enter `press`.
- On the enter `press` in each state, the matching strobe is issued:
  - `ENTER_A`: `load_A`
  - `ENTER_B`: `load_B`
  - `ENTER_OP`: `load_Op`
  - `SHOW_RES`: `updateRes`
- Whenever a strobe is issued, `data_in` is loaded with the value of `switches` sampled in the `press` cycle. `data_in` holds that value until the next strobe.
- For `load_Op`, `data_in[N-1:OP_W]` is forced to 0.
- For `updateRes`, `data_in` keeps its previous value.
- A clear `press` returns the FSM to `ENTER_A`, issues no strobe, and leaves `data_in` unchanged.
- If enter and clear `press` occur in the same cycle, clear wins and no strobe is issued.
- `step_leds`: bit0 = `ENTER_A`, bit1 = `ENTER_B`, bit2 = `ENTER_OP`, bit3 = `SHOW_RES`.
- At most one strobe is high in any cycle.

## Timing

- Reset values (asserted asynchronously on `reset` low):
  - `data_in` = 0
  - all strobes = 0
  - `step_leds` = 4'b0001
  - FSM in `ENTER_A`
  - synchronizers, debounce counters and debounced levels cleared to 0
- Reset release is synchronous to `clk`. The first `press` is possible no earlier than `DB_CYCLES`+3 cycles after release.
- Press latency: a raw level that is clean from cycle 0 gives `press` at cycle 2+`DB_CYCLES`. The strobe, new `data_in` and new `step_leds` are registered and appear in the following cycle.
- Strobe width is exactly one cycle, however long the button is held. No new press is recognized until a debounced release and a new debounced rise.
- A bounce shorter than `DB_CYCLES` restarts the stability count and causes no edge.
- Reset asserted mid-debounce or mid-strobe: the strobe drops immediately and no partial press survives.
- The debounce counter saturates and never wraps.

## Structure

- Package `alu_seq_pkg`:
  - `typedef enum logic [1:0] {ENTER_A, ENTER_B, ENTER_OP, SHOW_RES} seq_state_t`
  - step-to-LED constant
- Sub-module `btn_debouncer` (parameter `DB_CYCLES`; ports `clk`, `reset`, `btn_raw`, `press`). It contains the synchronizer, the saturating counter and the edge detector, and is instantiated twice.
- Top level holds the FSM, the `data_in` register and the strobe registers.

## Test plan

Run all scenarios with `DB_CYCLES`=4.

1. Reset, then release; hold `switches`=16'h0017 and give a clean enter pulse of 10 cycles → exactly one `load_A` cycle, `data_in`=16'h0017, `step_leds`=4'b0010.
2. Full sequence with `switches` 16'h0025, then 16'hFFF3, then any value for the fourth press → `load_B` with `data_in`=16'h0025; `load_Op` with `data_in`=16'h0003; `updateRes` with `data_in` unchanged at 16'h0003; FSM back in `ENTER_A`.
3. Enter input bounces 0/1 every 2 cycles for 20 cycles, then stays high → exactly one strobe, issued 7 cycles after the input settles (`press` at 2+`DB_CYCLES`, strobe one cycle later).
4. In `ENTER_OP`, enter and clear rise in the same cycle → no strobe, `step_leds`=4'b0001, `data_in` unchanged.
5. `reset` pulled low during the strobe cycle of `load_B` → `load_B` drops immediately, `data_in`=0, `step_leds`=4'b0001; the next strobe requires a full debounced press.
6. Enter held high for 100 cycles → exactly one strobe; a second strobe only after release and a new press.
